// File: rtl/packet_det_pkg.sv
// packet_det_pkg: shared widths and types for the packet-detect window accumulator
package packet_det_pkg;
  localparam int DIN_W = 32;
  localparam int LOG2_WIN_DEF = 4;
  localparam int HOLD_DEF = 3;
  localparam int ACC_W_DEF = DIN_W + LOG2_WIN_DEF;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;
  typedef logic signed [DIN_W-1:0] sample_t;
endpackage

// File: rtl/packet_det_delay_line.sv
// packet_det_delay_line: circular sample RAM whose async read returns the old word before the write lands
module packet_det_delay_line #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  assign rdata = mem[addr];
  // overwrite the slot whose old sample is leaving the window
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
endmodule

// File: rtl/packet_det_win_acc.sv
// packet_det_win_acc: sliding-window sum of product samples with hold-off threshold detect
module packet_det_win_acc #(
  parameter int DIN_W = packet_det_pkg::DIN_W,
  parameter int LOG2_WIN = packet_det_pkg::LOG2_WIN_DEF,
  parameter int ACC_W = DIN_W + LOG2_WIN,
  parameter int HOLD = packet_det_pkg::HOLD_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic signed [DIN_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] threshold,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_full,
  output logic                    det_flag,
  output logic                    det_pulse
);
  localparam logic [LOG2_WIN:0] WIN_CNT = (LOG2_WIN+1)'(2**LOG2_WIN);
  localparam logic [7:0] HOLD_CNT = 8'(HOLD);
  logic [LOG2_WIN-1:0] wptr_q, wptr_d;
  logic [LOG2_WIN:0] fill_q, fill_d;
  logic [7:0] run_q, run_d;
  logic signed [ACC_W-1:0] sum_q, sum_d, x, old;
  logic signed [DIN_W-1:0] rd;
  logic out_valid_q, out_valid_d, det_q, det_d, pulse_q, pulse_d, acc, full_d;
  packet_det_delay_line #(.DW(DIN_W), .AW(LOG2_WIN)) u_dl (
    .clk(ap_clk), .we(acc), .addr(wptr_q), .wdata(in_data), .rdata(rd)
  );
  assign in_ready = !out_valid_q || out_ready;
  assign acc = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum = sum_q;
  assign out_full = fill_q == WIN_CNT;
  assign det_flag = det_q;
  assign det_pulse = pulse_q;
  // window update and detect decision for the sample accepted this cycle
  always_comb begin
    x = ACC_W'(in_data);
    old = fill_q == WIN_CNT ? ACC_W'(rd) : '0;
    sum_d = acc ? sum_q + x - old : sum_q;
    fill_d = acc && fill_q != WIN_CNT ? fill_q + 1'b1 : fill_q;
    wptr_d = acc ? wptr_q + 1'b1 : wptr_q;
    full_d = fill_d == WIN_CNT;
    run_d = !acc ? run_q : (!full_d || sum_d < threshold) ? '0 : run_q == HOLD_CNT ? run_q : run_q + 1'b1;
    det_d = acc ? run_d == HOLD_CNT : det_q;
    pulse_d = acc && det_d && !det_q;
    out_valid_d = acc || (out_valid_q && !out_ready);
  end
  // state registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wptr_q <= '0;
      fill_q <= '0;
      run_q <= '0;
      sum_q <= '0;
      out_valid_q <= 1'b0;
      det_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      run_q <= run_d;
      sum_q <= sum_d;
      out_valid_q <= out_valid_d;
      det_q <= det_d;
      pulse_q <= pulse_d;
    end
  end
endmodule

// File: tb/tb_packet_det_win_acc.sv
// tb_packet_det_win_acc: scoreboard bench for the sliding-window detect accumulator
module tb_packet_det_win_acc;
  localparam int ACC_W = 36;
  localparam int HOLD = 3;
  typedef struct {longint s; bit f; bit d; bit p;} exp_t;
  logic ap_clk = 0, ap_rst = 0, in_valid = 0, out_ready = 1;
  logic signed [31:0] in_data = 0;
  logic signed [ACC_W-1:0] threshold = 0;
  logic in_ready, out_valid, out_full, det_flag, det_pulse;
  logic signed [ACC_W-1:0] out_sum;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  longint hist[$];
  longint m_thr = 0, last_sum = 0;
  int m_run = 0;
  bit m_ov = 0, m_det = 0;
  packet_det_win_acc dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .threshold(threshold), .out_sum(out_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_full(out_full), .det_flag(det_flag), .det_pulse(det_pulse)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_thr(input longint t);
    m_thr = t;
    threshold = ACC_W'(t);
  endtask
  task automatic do_reset();
    ap_rst = 1;
    in_valid = 0;
    out_ready = 1;
    @(posedge ap_clk);
    #1;
    ap_rst = 0;
    check("rst_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_full", out_full, 0);
    check("rst_det", det_flag, 0);
    check("rst_pulse", det_pulse, 0);
    sb.delete();
    hist.delete();
    m_run = 0;
    m_ov = 0;
    m_det = 0;
    last_sum = 0;
  endtask
  task automatic step(input bit v, input longint d, input bit ordy);
    bit rdy, acc;
    exp_t e;
    longint s;
    in_valid = v;
    in_data = 32'(d);
    out_ready = ordy;
    #1;
    rdy = !m_ov || ordy;
    check("in_ready", in_ready, rdy);
    acc = v && rdy;
    if (acc) begin
      hist.push_back(longint'(in_data));
      if (hist.size() > 16) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      e.s = s;
      e.f = hist.size() == 16;
      m_run = !e.f || s < m_thr ? 0 : (m_run < HOLD ? m_run + 1 : HOLD);
      e.d = m_run == HOLD;
      e.p = e.d && !m_det;
      m_det = e.d;
      sb.push_back(e);
    end
    m_ov = acc || (m_ov && !ordy);
    @(posedge ap_clk);
    #1;
    check("out_valid", out_valid, m_ov);
    check("det_flag", det_flag, m_det);
    if (acc) begin
      e = sb.pop_front();
      check("sum", out_sum, e.s);
      check("full", out_full, e.f);
      check("pulse", det_pulse, e.p);
      last_sum = e.s;
    end else begin
      check("idle_pulse", det_pulse, 0);
      if (m_ov) check("hold_sum", out_sum, last_sum);
    end
  endtask
  task automatic fill_check();
    for (int i = 0; i < 16; i++) begin
      step(1, 10, 1);
      check("fill_sum", out_sum, 10 * (i + 1));
      check("fill_full", out_full, i == 15);
    end
  endtask
  initial begin
    longint neg = -(longint'(1) <<< 31);
    longint pos = (longint'(1) <<< 31) - 1;
    set_thr(1000);
    do_reset();
    fill_check();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1);
      check("drain_sum", out_sum, 150 - 10 * i);
    end
    set_thr(100);
    for (int i = 0; i < 3; i++) begin
      step(1, 10, 1);
      check("hold_det", det_flag, i == 2);
      check("hold_pulse", det_pulse, i == 2);
    end
    step(1, -11, 1);
    check("drop_sum", out_sum, 99);
    check("drop_det", det_flag, 0);
    for (int i = 0; i < 3; i++) step(1, 20, 1);
    check("bp_det", det_flag, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 30, 0);
      check("bp_ready", in_ready, 0);
      check("bp_sum", out_sum, 129);
    end
    step(1, 30, 1);
    check("bp_resume", out_sum, 149);
    step(0, 0, 1);
    set_thr(0);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, neg, 1);
    check("neg_sum", out_sum, -(longint'(1) <<< 35));
    for (int i = 0; i < 16; i++) step(1, pos, 1);
    check("pos_sum", out_sum, 16 * pos);
    set_thr(1000);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 7, 1);
    do_reset();
    fill_check();
    set_thr(0);
    for (int i = 0; i < 80; i++)
      step(bit'($urandom_range(0, 1)), longint'($urandom_range(0, 200)) - 100, bit'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
